// File: rtl/period_tracker.sv
// School-day period sequencer: follows minute ticks from the timer block and
// steps through class and break periods starting at FIRST_HOUR:00.
module period_tracker #(
  parameter int FIRST_HOUR  = 9,
  parameter int PERIOD_MIN  = 50,
  parameter int BREAK_MIN   = 10,
  parameter int NUM_PERIODS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] time_in,
  input  logic        day_end,
  output logic [3:0]  period,
  output logic        in_class,
  output logic        in_break,
  output logic        period_start,
  output logic        period_end,
  output logic        day_done,
  output logic [5:0]  elapsed_min,
  output logic        time_err
);

  // state   | meaning
  // S_IDLE  | waiting for the first-period start time
  // S_CLASS | a class period is running
  // S_BREAK | break between two class periods
  // S_DONE  | last period finished, holding until day_end
  typedef enum logic [1:0] {S_IDLE, S_CLASS, S_BREAK, S_DONE} state_t;

  localparam logic [10:0] START_TIME  = {5'(FIRST_HOUR), 6'd0};
  localparam logic [5:0]  PERIOD_LEN  = 6'(PERIOD_MIN);
  localparam logic [5:0]  BREAK_LEN   = 6'(BREAK_MIN);
  localparam logic [3:0]  LAST_PERIOD = 4'(NUM_PERIODS);

  state_t      state, state_nx;
  logic [10:0] prev_time;
  logic        first_cyc;
  logic        armed, armed_nx;
  logic        time_valid, tick;
  logic [3:0]  period_nx;
  logic [5:0]  elapsed_nx, elapsed_inc;
  logic        start_nx, end_nx;

  assign time_valid  = (time_in[10:6] <= 5'd23) && (time_in[5:0] <= 6'd59);
  assign tick        = !first_cyc && time_valid && (time_in != prev_time);
  assign elapsed_inc = elapsed_min + 6'd1;

  // armed drops once the clock has run past the start time in IDLE, so a
  // missed start is not picked up later the same day.
  always_comb begin
    state_nx   = state;
    period_nx  = period;
    elapsed_nx = elapsed_min;
    start_nx   = 1'b0;
    end_nx     = 1'b0;
    armed_nx   = armed;
    if (day_end) begin
      state_nx   = S_IDLE;
      period_nx  = 4'd0;
      elapsed_nx = 6'd0;
      end_nx     = (state == S_CLASS);
      armed_nx   = 1'b1;
    end else if (tick) begin
      unique case (state)
        S_IDLE: begin
          if (armed && (time_in == START_TIME)) begin
            state_nx   = S_CLASS;
            period_nx  = 4'd1;
            elapsed_nx = 6'd0;
            start_nx   = 1'b1;
          end else if (time_in > START_TIME) begin
            armed_nx = 1'b0;
          end
        end
        S_CLASS: begin
          if (elapsed_inc == PERIOD_LEN) begin
            end_nx     = 1'b1;
            elapsed_nx = 6'd0;
            if (period < LAST_PERIOD) begin
              state_nx = S_BREAK;
            end else begin
              state_nx  = S_DONE;
              period_nx = 4'd0;
            end
          end else begin
            elapsed_nx = elapsed_inc;
          end
        end
        S_BREAK: begin
          if (elapsed_inc == BREAK_LEN) begin
            state_nx   = S_CLASS;
            period_nx  = period + 4'd1;
            elapsed_nx = 6'd0;
            start_nx   = 1'b1;
          end else begin
            elapsed_nx = elapsed_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      prev_time    <= 11'd0;
      first_cyc    <= 1'b1;
      armed        <= 1'b1;
      period       <= 4'd0;
      elapsed_min  <= 6'd0;
      in_class     <= 1'b0;
      in_break     <= 1'b0;
      day_done     <= 1'b0;
      period_start <= 1'b0;
      period_end   <= 1'b0;
      time_err     <= 1'b0;
    end else begin
      state        <= state_nx;
      prev_time    <= time_in;
      first_cyc    <= 1'b0;
      armed        <= armed_nx;
      period       <= period_nx;
      elapsed_min  <= elapsed_nx;
      in_class     <= (state_nx == S_CLASS);
      in_break     <= (state_nx == S_BREAK);
      day_done     <= (state_nx == S_DONE);
      period_start <= start_nx;
      period_end   <= end_nx;
      time_err     <= !time_valid;
    end
  end

endmodule

// File: tb/tb_period_tracker.sv
// Randomized bench for period_tracker against a tick-count model of the school day.
module tb_period_tracker;

  localparam int FH = 9;
  localparam int P  = 5;
  localparam int B  = 3;
  localparam int N  = 3;
  localparam int L  = P + B;
  localparam int DAY_LEN = N * P + (N - 1) * B;
  localparam logic [10:0] START = {5'(FH), 6'd0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] time_in = 11'd0;
  logic        day_end = 1'b0;
  logic [3:0]  period;
  logic        in_class, in_break, period_start, period_end, day_done, time_err;
  logic [5:0]  elapsed_min;

  period_tracker #(.FIRST_HOUR(FH), .PERIOD_MIN(P), .BREAK_MIN(B), .NUM_PERIODS(N)) dut (
    .clk(clk), .rst(rst), .time_in(time_in), .day_end(day_end),
    .period(period), .in_class(in_class), .in_break(in_break),
    .period_start(period_start), .period_end(period_end), .day_done(day_done),
    .elapsed_min(elapsed_min), .time_err(time_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
  endtask

  // model: mode 0 idle, 1 running (m_t ticks since the start tick), 2 done
  int          m_mode, m_t;
  bit          m_armed, m_first;
  logic [10:0] m_prev;
  int e_period, e_elapsed;
  bit e_class, e_break, e_done, e_start, e_end, e_err;

  task automatic derive();
    e_period = 0; e_elapsed = 0; e_class = 0; e_break = 0; e_done = 0;
    if (m_mode == 1) begin
      e_period = m_t / L + 1;
      if ((m_t % L) < P) begin e_class = 1; e_elapsed = m_t % L; end
      else begin e_break = 1; e_elapsed = (m_t % L) - P; end
    end else if (m_mode == 2) begin
      e_done = 1;
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_armed = 1; m_first = 1; m_prev = 11'd0;
    e_start = 0; e_end = 0; e_err = 0;
    derive();
  endtask

  task automatic model_step(input logic [10:0] t, input bit de);
    bit valid, tk;
    valid = (t[10:6] <= 23) && (t[5:0] <= 59);
    tk = !m_first && valid && (t != m_prev);
    e_err = !valid; e_start = 0; e_end = 0;
    m_first = 0; m_prev = t;
    if (de) begin
      e_end = (m_mode == 1) && ((m_t % L) < P);
      m_mode = 0; m_armed = 1;
    end else if (tk) begin
      if (m_mode == 0) begin
        if (m_armed && t == START) begin m_mode = 1; m_t = 0; e_start = 1; end
        else if (t > START) m_armed = 0;
      end else if (m_mode == 1) begin
        m_t++;
        if (m_t == DAY_LEN) begin m_mode = 2; e_end = 1; end
        else begin
          if ((m_t % L) == 0) e_start = 1;
          if ((m_t % L) == P) e_end = 1;
        end
      end
    end
    derive();
  endtask

  task automatic compare_all();
    chk_val("period", 16'(period), 16'(e_period));
    chk_val("elapsed_min", 16'(elapsed_min), 16'(e_elapsed));
    chk_val("in_class", 16'(in_class), 16'(e_class));
    chk_val("in_break", 16'(in_break), 16'(e_break));
    chk_val("day_done", 16'(day_done), 16'(e_done));
    chk_val("period_start", 16'(period_start), 16'(e_start));
    chk_val("period_end", 16'(period_end), 16'(e_end));
    chk_val("time_err", 16'(time_err), 16'(e_err));
  endtask

  function automatic logic [10:0] hm(input int minutes);
    return {5'(minutes / 60), 6'(minutes % 60)};
  endfunction

  // check previous edge's outputs, then drive the next inputs; with r set the
  // outputs must already be zero before any further clock edge
  task automatic cyc(input logic [10:0] t, input bit de, input bit r);
    @(negedge clk);
    compare_all();
    rst = r; time_in = t; day_end = de;
    if (r) begin
      model_reset();
      #1 compare_all();
    end else begin
      model_step(t, de);
    end
  endtask

  int cur;

  initial begin
    model_reset();
    repeat (3) cyc(11'd0, 0, 1);

    // normal day from 08:58 through DONE, then day_end
    cur = 8 * 60 + 58;
    repeat (DAY_LEN + 6) begin cyc(hm(cur), 0, 0); cur++; end
    cyc(hm(cur), 1, 0);

    // day_end coinciding with the 09:00 tick must not start the day
    cyc(hm(8 * 60 + 59), 0, 0);
    cyc(hm(9 * 60), 1, 0);
    repeat (2) cyc(hm(9 * 60), 0, 0);
    cyc(hm(9 * 60), 1, 0);

    // invalid time mid-class, then async reset mid-class
    cyc(hm(8 * 60 + 59), 0, 0);
    cur = 9 * 60;
    repeat (3) begin cyc(hm(cur), 0, 0); cur++; end
    cyc(11'h7FF, 0, 0);
    cyc(hm(cur), 0, 0); cur++;
    cyc(hm(cur), 0, 0);
    repeat (2) cyc(hm(cur), 0, 1);
    repeat (3) cyc(hm(cur), 0, 0);

    // randomized days
    for (int d = 0; d < 25; d++) begin
      cur = 8 * 60 + 50 + int'($urandom_range(0, 9));
      cyc(hm(cur), 1, 0);
      for (int i = 0; i < 120; i++) begin
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 30) cyc(hm(cur), 0, 0);
        else if (r < 92) begin cur = (cur + 1) % 1440; cyc(hm(cur), 0, 0); end
        else if (r < 95) begin
          if ($urandom_range(0, 1) == 0)
            cyc({5'(24 + $urandom_range(0, 7)), 6'($urandom_range(0, 63))}, 0, 0);
          else
            cyc({5'($urandom_range(0, 31)), 6'(60 + $urandom_range(0, 3))}, 0, 0);
        end
        else if (r < 97) begin cur = (cur + int'($urandom_range(1, 30))) % 1440; cyc(hm(cur), 0, 0); end
        else if (r < 99) cyc(hm(cur), 1, 0);
        else cyc(hm(cur), 0, 1);
      end
    end

    @(negedge clk);
    compare_all();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/period_tracker.md
PERIOD_TRACKER -- requirements
Module: period_tracker

Interface
REQ-001 Parameter FIRST_HOUR, default 9: hour at which period 1 starts (minute 0); legal range 0..23.
REQ-002 Parameter PERIOD_MIN, default 50: class length in minute ticks; legal range 1..63.
REQ-003 Parameter BREAK_MIN, default 10: break length in minute ticks; legal range 1..63.
REQ-004 Parameter NUM_PERIODS, default 8: periods per day; legal range 1..15.
REQ-005 clk  in  1  single clock; all state updates on posedge clk.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 time_in  in  11  {hour[4:0], min[5:0]} from the timer block's time_out.
REQ-008 day_end  in  1  end-of-day strobe, driven by the timer block's rst_timer.
REQ-009 period  out  4  current period number 1..NUM_PERIODS; 0 in IDLE and DONE.
REQ-010 in_class  out  1  high while state is CLASS.
REQ-011 in_break  out  1  high while state is BREAK.
REQ-012 period_start  out  1  one-cycle pulse on entry to CLASS.
REQ-013 period_end  out  1  one-cycle pulse on exit from CLASS.
REQ-014 day_done  out  1  high while state is DONE.
REQ-015 elapsed_min  out  6  minute ticks elapsed in the current CLASS or BREAK; 0 otherwise.
REQ-016 time_err  out  1  one-cycle pulse when a sampled time_in has hour>23 or min>59.

Function
REQ-017 The block SHALL register time_in every cycle into prev_time; a minute tick SHALL occur in a cycle where time_in is valid and differs from prev_time.
REQ-018 The first cycle after reset release SHALL load prev_time without generating a tick.
REQ-019 An invalid time_in SHALL pulse time_err in the next cycle, generate no tick, and leave state, period and elapsed_min unchanged; prev_time still updates.
REQ-020 States SHALL be IDLE, CLASS, BREAK and DONE; all outputs SHALL be registered.
REQ-021 IDLE->CLASS on a tick with time_in == {FIRST_HOUR, 0}: period=1, elapsed_min=0, period_start=1.
REQ-022 In CLASS each tick SHALL increment elapsed_min; the tick that makes it equal PERIOD_MIN SHALL pulse period_end and clear elapsed_min.
REQ-023 On that tick the next state SHALL be BREAK if period<NUM_PERIODS, else DONE with period=0.
REQ-024 In BREAK each tick SHALL increment elapsed_min; the tick that makes it equal BREAK_MIN SHALL enter CLASS, increment period, clear elapsed_min and pulse period_start.
REQ-025 DONE SHALL hold until day_end; ticks in DONE and IDLE SHALL be ignored apart from the REQ-021 start match.
REQ-026 day_end high in any state SHALL force IDLE next cycle: period=0, elapsed_min=0, all flags low.
REQ-027 If a period is in progress when day_end arrives, period_end SHALL pulse in the same cycle.
REQ-028 day_end SHALL take priority over a simultaneous tick; that tick is discarded, including a REQ-021 match.
REQ-029 If time_in skips past {FIRST_HOUR, 0}, for example after a jump, the block SHALL stay in IDLE until the next day_end.
REQ-030 period_start and period_end SHALL never both be high in one cycle, except under REQ-027, where period_start is low.
REQ-031 elapsed_min SHALL never exceed max(PERIOD_MIN, BREAK_MIN)-1 when observed.

Reset
REQ-032 On rst assertion, without waiting for clk: state=IDLE, prev_time=0, first-cycle flag set, all outputs 0.
REQ-033 rst asserted mid-period SHALL discard all progress; no period_end pulse.
REQ-034 After reset release, normal behaviour SHALL begin on the first posedge clk.

Verification
REQ-035 Defaults; time_in steps 08:58, 08:59, 09:00 -> period_start one cycle after the 09:00 sample, then period=1, in_class=1.
REQ-036 PERIOD_MIN=50; 50 ticks from 09:00 -> period_end pulse, in_break=1, period=1, elapsed_min=0. After 10 more ticks -> period_start, period=2.
REQ-037 NUM_PERIODS=2, PERIOD_MIN=2, BREAK_MIN=1; run the full day -> day_done=1, period=0. Then day_end -> IDLE.
REQ-038 day_end and time_in change to 09:00 in the same cycle -> state stays IDLE, no period_start.
REQ-039 time_in=11'b11111_111111 (hour 31, min 63) mid-CLASS -> time_err pulse; elapsed_min and state unchanged.
REQ-040 rst asserted between clock edges mid-CLASS -> all outputs 0 immediately. Release followed by constant time_in -> no tick.
